button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
//  Parametrised, multi-channel front end for raw board inputs (buttons, switches).
//  Each channel has a synchroniser, a counter-based debouncer and a press/release edge detector.
//  Supersedes the single-bit debouncer in the top level; one instance serves every board button.
//  Sits directly behind the board pins, ahead of the reset and harness logic.
// PARAMETERS
//  CHANNELS         4        number of independent input channels (>=1)
//  SYNC_STAGES      2        synchroniser flops per channel (>=2)
//  DEBOUNCE_CYCLES  1000000  consecutive stable cycles needed to accept a new level (>=1)
//  RESET_LEVEL      '0       [CHANNELS-1:0] debounced level loaded at reset, per channel
//  REPEAT_DELAY     50000000 hold cycles before the first auto-repeat press (macro build only)
//  REPEAT_PERIOD    10000000 cycles between subsequent auto-repeat presses (macro build only)
// PORTS
//  clock      in   1         single system clock
//  reset_n    in   1         asynchronous, active-low reset
//  raw_in     in   CHANNELS  asynchronous pin levels, active-high
//  level      out  CHANNELS  debounced level per channel
//  press      out  CHANNELS  1-cycle pulse per accepted 0->1 (plus repeats, see CONFIGURATION)
//  release    out  CHANNELS  1-cycle pulse per accepted 1->0
//  changed    out  1         OR of press|release, same cycle
// BEHAVIOUR
//  - reset_n low: async clear; sync flops <= RESET_LEVEL, level <= RESET_LEVEL, counters 0.
//    press/release/changed <= 0. A reset mid-settle discards the partial count.
//  - Per-channel FSM (debounced level L, synchronised sample s):
//    STABLE: s==L -> stay, count=0; s!=L -> SETTLING, count=1.
//    SETTLING: s==L -> STABLE, count=0 (glitch rejected).
//    SETTLING: s!=L and count==DEBOUNCE_CYCLES-1 -> STABLE, L<=s, count=0, fire pulse.
//    SETTLING: otherwise count++.
//    DEBOUNCE_CYCLES==1: accept on the first cycle s!=L; SETTLING is never held.
//  - All outputs are registered. press/release assert in the same cycle that level changes.
//  - Latency: a clean raw edge moves level exactly SYNC_STAGES+DEBOUNCE_CYCLES clock edges later.
//  - Rejection: a raw pulse shorter than DEBOUNCE_CYCLES cycles never changes level or fires.
//  - Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter never wraps; it is bounded by the accept rule.
//  - Channels are fully independent. Simultaneous accepts on several channels fire all pulses together.
//  - Exactly one pulse fires per accepted transition; press and release are never both high on a channel.
// CONFIGURATION
//  BUTTON_CONDITIONER_REPEAT_EN defined:
//    - While L==1, a per-channel repeat counter runs from the accept cycle.
//    - First extra press fires REPEAT_DELAY cycles after the original press.
//    - Further extra presses fire every REPEAT_PERIOD cycles.
//    - The counter clears on release or reset; release cancels any pending repeat in the same cycle.
//  Macro undefined:
//    - No repeat logic is generated; REPEAT_* are ignored.
//    - Exactly one press per accepted 0->1.
// STRUCTURE
//  - Package button_conditioner_pkg:
//    - state enum {STABLE, SETTLING}
//    - function cnt_width(n) = $clog2(n+1)
//    - default timing constants for a 100 MHz clock
//  - Sub-module debounce_channel: one synchroniser + FSM + counter + optional repeat.
//    Generated CHANNELS times; the top only builds the ORed changed output.
// TESTING (bench: CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
//  1. Reset: reset_n=0 with RESET_LEVEL=4'b0010.
//     -> level=4'b0010, press=release=0, changed=0, all asynchronous without a clock edge.
//  2. Clean press: raw_in[0] 0->1 and held.
//     -> level[0] rises exactly 6 edges later; press[0] high that one cycle only.
//     -> changed=1 in the same cycle.
//  3. Glitch: raw_in[1] high for 3 cycles, then low.
//     -> level, press and release stay 0 throughout.
//     -> A 4-cycle pulse, by contrast, fires press then (after 6) release.
//  4. Bounce: raw_in[2] toggles 1,0,1,1,0,1,1,1,1.
//     -> a single press[2], 6 edges after the last 0->1.
//     -> no release pulse.
//  5. Simultaneous: raw_in[3:0] 0->4'b1111 together, then all 0.
//     -> press=4'b1111 in one cycle; later release=4'b1111 in one cycle.
//  6. Repeat (macro on): hold raw_in[0] high.
//     -> presses at accept, +20, +28 and +36 cycles.
//     -> release then stops repeats.
//     Same stimulus with the macro off -> exactly one press.
//  7. Reset mid-settle: pulse reset_n low during SETTLING.
//     -> after release of reset, a fresh full 6-edge latency applies.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// button_conditioner_pkg
// Shared types, constants and helpers for the button conditioner.
//   state_t    : per-channel debounce FSM state {STABLE, SETTLING}
//   cnt_width  : bits needed to hold the values 0..n
//   DEF_*      : default timing for a 100 MHz system clock
// ---------------------------------------------------------------------------
package button_conditioner_pkg;

    typedef enum logic [0:0] {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_t;

    // 100 MHz defaults: 10 ms debounce, 500 ms first repeat, 100 ms repeat rate
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One input channel: synchroniser, counter-based debouncer and press/release
// edge detector, plus optional hold-to-repeat presses.
// Optional feature macro: BUTTON_CONDITIONER_REPEAT_EN (auto-repeat presses).
// Ports:
//   clock          in   system clock
//   reset_n        in   asynchronous active-low reset
//   raw_in         in   asynchronous pin level
//   level          out  debounced level (registered)
//   press          out  1-cycle pulse on accepted 0->1 and on repeats (registered)
//   release_pulse  out  1-cycle pulse on accepted 1->0 (registered)
//   pulse_next     out  value press|release_pulse takes at the next edge
// ---------------------------------------------------------------------------
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic RESET_BIT       = 1'b0,
    parameter int   REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int   REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_in,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic pulse_next
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   sample;
    logic                   accept;
    logic                   repeat_fire;

    assign sample = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in};
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        accept  = 1'b0;
        case (state_q)
            STABLE: begin
                if (sample != level_q) begin
                    // A one-cycle debounce accepts immediately, never settling
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = SETTLING;
                        cnt_d   = CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            SETTLING: begin
                if (sample == level_q) begin
                    state_d = STABLE;       // glitch: back to the old level
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
        if (accept) begin
            state_d = STABLE;
            cnt_d   = '0;
            level_d = sample;
        end
    end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = cnt_width(REP_MAX);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;   // first (long) repeat already fired

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        repeat_fire = 1'b0;
        if (accept) begin
            // Any accepted transition restarts the timer; a release here
            // also suppresses a repeat that would have landed this cycle.
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
        end else if (level_q) begin
            if (!rep_first_q && rep_cnt_q == REP_W'(REPEAT_DELAY - 1)) begin
                repeat_fire = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end else if (rep_first_q && rep_cnt_q == REP_W'(REPEAT_PERIOD - 1)) begin
                repeat_fire = 1'b1;
                rep_cnt_d   = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    // Repeat timing is not built; the expression is constant zero.
    assign repeat_fire = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif

    assign press_d    = (accept && sample) || repeat_fire;
    assign release_d  = accept && !sample;
    assign pulse_next = press_d || release_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= {SYNC_STAGES{RESET_BIT}};
            state_q   <= STABLE;
            cnt_q     <= '0;
            level_q   <= RESET_BIT;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Multi-channel conditioner for raw board inputs: each channel is synchronised,
// debounced and edge-detected independently by a debounce_channel instance.
// Optional feature macro: BUTTON_CONDITIONER_REPEAT_EN (auto-repeat presses).
// Ports:
//   clock          in   system clock
//   reset_n        in   asynchronous active-low reset
//   raw_in         in   [CHANNELS] asynchronous pin levels, active-high
//   level          out  [CHANNELS] debounced levels
//   press          out  [CHANNELS] 1-cycle press pulses
//   release_pulse  out  [CHANNELS] 1-cycle release pulses ("release" is a
//                       reserved word in SystemVerilog, hence the suffix)
//   changed        out  OR of all press/release pulses, same cycle
// ---------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int                  CHANNELS        = 4,
    parameter int                  SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int                  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [CHANNELS-1:0] RESET_LEVEL     = '0,
    parameter int                  REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int                  REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                changed
);

    logic [CHANNELS-1:0] pulse_next;
    logic                changed_q, changed_d;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            debounce_channel #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_BIT       (RESET_LEVEL[gi]),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_ch (
                .clock         (clock),
                .reset_n       (reset_n),
                .raw_in        (raw_in[gi]),
                .level         (level[gi]),
                .press         (press[gi]),
                .release_pulse (release_pulse[gi]),
                .pulse_next    (pulse_next[gi])
            );
        end
    endgenerate

    // Registered from the channels' next-cycle pulses so it lines up exactly
    // with press/release_pulse.
    assign changed_d = |pulse_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;

endmodule
